// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RISC-V M-extension multiply/divide unit.
// Operation encodings follow funct3; helpers classify operand signedness.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } MulDivOp;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } MulDivState;

   function automatic logic op_is_div(input MulDivOp op);
      return op[2];
   endfunction

   // MUL keeps only the low half, which is identical for signed and unsigned.
   function automatic logic op_rs1_signed(input MulDivOp op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_rs2_signed(input MulDivOp op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, and selection
// plus negation of the raw magnitude result on exit.
module muldiv_sign_fix
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  MulDivOp           i_op,
   input  logic [XLEN-1:0]   i_opr1,
   input  logic [XLEN-1:0]   i_opr2,
   output logic [XLEN-1:0]   o_abs1,
   output logic [XLEN-1:0]   o_abs2,
   output logic              o_neg1,
   output logic              o_neg2,
   input  MulDivOp           i_fin_op,
   input  logic              i_fin_neg1,
   input  logic              i_fin_neg2,
   input  logic [XLEN-1:0]   i_hi,
   input  logic [XLEN-1:0]   i_lo,
   output logic [XLEN-1:0]   o_result
);

   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_fix;

   always_comb begin
      o_neg1 = op_rs1_signed(i_op) & i_opr1[XLEN-1];
      o_neg2 = op_rs2_signed(i_op) & i_opr2[XLEN-1];
      o_abs1 = o_neg1 ? -i_opr1 : i_opr1;
      o_abs2 = o_neg2 ? -i_opr2 : i_opr2;
   end

   // Multiply: {hi,lo} is the product; divide: hi is remainder, lo is quotient.
   always_comb begin
      w_prod     = {i_hi, i_lo};
      w_prod_fix = (i_fin_neg1 ^ i_fin_neg2) ? -w_prod : w_prod;
      case (i_fin_op)
         OP_MUL:                       o_result = w_prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
         OP_DIV:  o_result = (i_fin_neg1 ^ i_fin_neg2) ? -i_lo : i_lo;
         OP_REM:  o_result = i_fin_neg1 ? -i_hi : i_hi;
         OP_DIVU: o_result = i_lo;
         OP_REMU: o_result = i_hi;
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes, BPC bits per cycle, with a bypass for divide-by-zero/overflow.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [2:0]        i_op,
   input  logic [XLEN-1:0]   i_opr1,
   input  logic [XLEN-1:0]   i_opr2,
   input  logic              i_flush,
   output logic              o_stall_req,
   output logic              o_done,
   output logic [XLEN-1:0]   o_result,
   output logic              o_busy
);

   localparam int N  = XLEN / BPC;
   localparam int CW = $clog2(N) + 1;

   MulDivState        r_state;
   MulDivState        w_state_next;
   MulDivOp           r_op;
   MulDivOp           w_op;
   logic [CW-1:0]     r_cnt;
   logic              r_neg1, r_neg2, r_bypass, r_done;
   logic [XLEN-1:0]   r_hi, r_lo, r_dvsr, r_result;

   logic [XLEN-1:0]   w_abs1, w_abs2, w_final, w_special_res;
   logic              w_neg1, w_neg2, w_accept, w_div_zero, w_ovf, w_special;
   logic [XLEN-1:0]   w_hi_it, w_lo_it;
   logic [XLEN:0]     w_trial, w_diff, w_sum;

   assign w_op = MulDivOp'(i_op);

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .i_op       (w_op),
      .i_opr1     (i_opr1),
      .i_opr2     (i_opr2),
      .o_abs1     (w_abs1),
      .o_abs2     (w_abs2),
      .o_neg1     (w_neg1),
      .o_neg2     (w_neg2),
      .i_fin_op   (r_op),
      .i_fin_neg1 (r_neg1),
      .i_fin_neg2 (r_neg2),
      .i_hi       (r_hi),
      .i_lo       (r_lo),
      .o_result   (w_final)
   );

   always_comb begin
      w_accept   = (r_state == ST_IDLE) & i_start & ~i_flush;
      w_div_zero = op_is_div(w_op) && (i_opr2 == '0);
      w_ovf      = (w_op == OP_DIV || w_op == OP_REM) &&
                   (i_opr1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_opr2 == '1);
      w_special  = w_div_zero | w_ovf;
      if (w_div_zero)
         w_special_res = (w_op == OP_DIV || w_op == OP_DIVU) ? '1 : i_opr1;
      else
         w_special_res = (w_op == OP_DIV) ? i_opr1 : '0;
   end

   // BPC iterations unrolled; hi/lo are remainder/quotient or product halves.
   always_comb begin
      w_hi_it = r_hi;
      w_lo_it = r_lo;
      w_trial = '0;
      w_diff  = '0;
      w_sum   = '0;
      for (int k = 0; k < BPC; k++) begin
         if (op_is_div(r_op)) begin
            w_trial = {w_hi_it, w_lo_it[XLEN-1]};
            w_diff  = w_trial - {1'b0, r_dvsr};
            if (!w_diff[XLEN]) begin
               w_hi_it = w_diff[XLEN-1:0];
               w_lo_it = {w_lo_it[XLEN-2:0], 1'b1};
            end else begin
               w_hi_it = w_trial[XLEN-1:0];
               w_lo_it = {w_lo_it[XLEN-2:0], 1'b0};
            end
         end else begin
            w_sum   = {1'b0, w_hi_it} + (w_lo_it[0] ? {1'b0, r_dvsr} : '0);
            w_hi_it = w_sum[XLEN:1];
            w_lo_it = {w_sum[0], w_lo_it[XLEN-1:1]};
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_next = w_special ? ST_DONE : ST_BUSY;
         ST_BUSY: if (r_cnt == CW'(N-1)) w_state_next = ST_DONE;
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
      if (i_flush) w_state_next = ST_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op     <= OP_MUL;
         r_cnt    <= '0;
         r_neg1   <= 1'b0;
         r_neg2   <= 1'b0;
         r_bypass <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_dvsr   <= '0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_flush) begin
            r_cnt <= '0;
         end else begin
            case (r_state)
               ST_IDLE: if (i_start) begin
                  r_op     <= w_op;
                  r_neg1   <= w_neg1;
                  r_neg2   <= w_neg2;
                  r_cnt    <= '0;
                  r_bypass <= w_special;
                  r_hi     <= '0;
                  r_lo     <= op_is_div(w_op) ? w_abs1 : w_abs2;
                  r_dvsr   <= op_is_div(w_op) ? w_abs2 : w_abs1;
                  if (w_special) begin
                     r_result <= w_special_res;
                     r_done   <= 1'b1;
                  end
               end
               ST_BUSY: begin
                  r_hi  <= w_hi_it;
                  r_lo  <= w_lo_it;
                  r_cnt <= r_cnt + CW'(1);
               end
               ST_DONE: begin
                  r_cnt <= '0;
                  if (!r_bypass) begin
                     r_result <= w_final;
                     r_done   <= 1'b1;
                  end
               end
               default: r_cnt <= '0;
            endcase
         end
      end
   end

   assign o_done      = r_done;
   assign o_result    = r_result;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_stall_req = i_rst_n &
                        ((i_start & (r_state == ST_IDLE)) | (r_state == ST_BUSY));

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected result and done
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        i_rst_n, i_start, i_flush;
   logic [2:0]  i_op;
   logic [31:0] i_opr1, i_opr2;
   logic        o_stall_req, o_done, o_busy;
   logic [31:0] o_result;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          stall_total = 0;
   int          done_cnt = 0;
   logic [31:0] last_res = '0;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                          DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

   muldiv_unit #(.XLEN(32), .BPC(1)) dut (
      .i_clk       (clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_op        (i_op),
      .i_opr1      (i_opr1),
      .i_opr2      (i_opr2),
      .i_flush     (i_flush),
      .o_stall_req (o_stall_req),
      .o_done      (o_done),
      .o_result    (o_result),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (o_stall_req) stall_total++;

   always @(negedge clk) begin
      if (i_rst_n && o_done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: result=%h at cycle %0d, no operation pending", o_result, cyc);
         end else begin
            mon_e = sb.pop_front();
            total++;
            if (o_result !== mon_e.res) begin
               bad++;
               $display("FAIL %s result: got %h want %h", mon_e.name, o_result, mon_e.res);
            end
            total++;
            if (cyc != mon_e.cyc) begin
               bad++;
               $display("FAIL %s latency: done at cycle %0d want %0d", mon_e.name, cyc, mon_e.cyc);
            end
            $display("op %-14s result=%h cycle=%0d", mon_e.name, o_result, cyc);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit bypass, input string name);
      exp_t e;
      int   st0;
      @(posedge clk); #1;
      st0     = stall_total;
      i_start = 1'b1; i_op = op; i_opr1 = a; i_opr2 = b;
      e.res  = exp;
      e.cyc  = cyc + (bypass ? 1 : 34);
      e.name = name;
      sb.push_back(e);
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL %s timeout: no done within 60 cycles", name);
         sb.delete();
      end
      check({name, " stall"}, 32'(stall_total - st0), bypass ? 32'd1 : 32'd33);
      last_res = exp;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      i_rst_n = 1'b0; i_start = 1'b1; i_flush = 1'b0;
      i_op = MUL; i_opr1 = 32'd3; i_opr2 = 32'd4;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset stall_req", {31'd0, o_stall_req}, 32'd0);
      check("reset busy",      {31'd0, o_busy},      32'd0);
      check("reset done",      {31'd0, o_done},      32'd0);
      check("reset result",    o_result,             32'd0);
      i_start = 1'b0;
      @(posedge clk); #1;
      i_rst_n = 1'b1;

      do_op(MUL,    32'd7,        32'd6,        32'd42,       0, "MUL 7*6");
      do_op(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0, "MULH min*min");
      do_op(MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 0, "MULHU");
      do_op(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, "MULHSU -1*2");
      do_op(MUL,    32'd0,        32'd12345,    32'd0,        0, "MUL 0*x");
      do_op(MUL,    32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 0, "MUL -1*3");
      do_op(MULH,   32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF, 0, "MULH -1*3");
      do_op(MULHU,  32'hFFFFFFFF, 32'd3,        32'h00000002, 0, "MULHU ff*3");
      do_op(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, "DIV -7/2");
      do_op(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, "REM -7%2");
      do_op(DIVU,   32'd100,      32'd7,        32'd14,       0, "DIVU 100/7");
      do_op(REMU,   32'd100,      32'd7,        32'd2,        0, "REMU 100%7");
      do_op(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, "DIV 7/-2");
      do_op(REM,    32'd7,        32'hFFFFFFFE, 32'd1,        0, "REM 7%-2");
      do_op(DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1, "DIVU 5/0");
      do_op(REMU,   32'd5,        32'd0,        32'd5,        1, "REMU 5%0");
      do_op(DIV,    32'd7,        32'd0,        32'hFFFFFFFF, 1, "DIV 7/0");
      do_op(REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1, "REM -7%0");
      do_op(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "DIV ovf");
      do_op(REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "REM ovf");
      do_op(DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        0, "DIVU no-ovf");

      // Flush in the tenth BUSY cycle.
      dc = done_cnt;
      @(posedge clk); #1;
      i_start = 1'b1; i_op = MUL; i_opr1 = 32'd123; i_opr2 = 32'd456;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (9) @(posedge clk);
      #1 i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      check("flush busy",   {31'd0, o_busy}, 32'd0);
      check("flush done",   {31'd0, o_done}, 32'd0);
      check("flush result", o_result, last_res);
      check("flush no done", 32'(done_cnt), 32'(dc));
      $display("op flush        result=%h busy=%0d", o_result, o_busy);
      do_op(DIVU,   32'd100,      32'd7,        32'd14,       0, "DIVU post-flush");

      // Reset in the fifth BUSY cycle.
      @(posedge clk); #1;
      i_start = 1'b1; i_op = MUL; i_opr1 = 32'd9; i_opr2 = 32'd9;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (4) @(posedge clk);
      #2 i_rst_n = 1'b0;
      #1;
      check("rst busy",      {31'd0, o_busy},      32'd0);
      check("rst done",      {31'd0, o_done},      32'd0);
      check("rst result",    o_result,             32'd0);
      check("rst stall_req", {31'd0, o_stall_req}, 32'd0);
      repeat (2) @(posedge clk);
      #1 i_rst_n = 1'b1;
      dc = done_cnt;
      repeat (40) @(posedge clk);
      #1;
      check("rst no done", 32'(done_cnt), 32'(dc));
      $display("op reset-abort  result=%h busy=%0d", o_result, o_busy);
      do_op(MUL,    32'd7,        32'd6,        32'd42,       0, "MUL after rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
